link_hang_monitor: RTL and testbench



---
 rtl/link_hang_monitor.sv | 161 ++++++++++++++++
 tb/tb_link_hang_monitor.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/link_hang_monitor.sv
// link_hang_monitor: passive observer on a credit-based NoC link.
// Parses packet headers as they transfer, measures stall gaps inside each
// packet, drives a live hang alarm and posts a one-entry end-of-packet report.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | between packets; next transfer is a header
//   SRCPE     | header seen, waiting for the source-PE flit
//   EDGE      | delivery packet, waiting for the sender/receiver flit
//   TIMESTAMP | delivery packet, waiting for the timestamp flit
//   PAYLOAD   | remaining flits, only eop matters
module link_hang_monitor #(
    parameter logic [31:0] THRESHOLD     = 32'd64,
    parameter logic        DELIVERY_ONLY = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        tx_i,
    input  logic        cr_i,
    input  logic        eop_i,
    input  logic [31:0] data_i,
    output logic        alarm_o,
    output logic        rpt_valid_o,
    input  logic        rpt_ready_i,
    output logic [15:0] rpt_sender_o,
    output logic [15:0] rpt_receiver_o,
    output logic [31:0] rpt_timestamp_o,
    output logic [31:0] rpt_max_gap_o,
    output logic [7:0]  rpt_dropped_o
);

    // Service code of MESSAGE_DELIVERY, mirroring the task injector package.
    localparam logic [7:0] MESSAGE_DELIVERY = 8'h03;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SRCPE     = 3'd1;
    localparam logic [2:0] EDGE      = 3'd2;
    localparam logic [2:0] TIMESTAMP = 3'd3;
    localparam logic [2:0] PAYLOAD   = 3'd4;

    logic [2:0]  state, state_nxt;
    logic [7:0]  service;
    logic [15:0] sender, receiver;
    logic [31:0] timestamp, gap, max_gap;

    logic        xfer;
    logic [7:0]  pkt_service;
    logic [15:0] pkt_sender, pkt_receiver;
    logic [31:0] pkt_timestamp, pkt_max;
    logic        eligible, pkt_eligible, rpt_fire, rpt_load;

    assign xfer = tx_i & cr_i;

    // Packet fields as they stand after the current transfer; a header
    // restarts them from zero, so a header-only packet reports clean values.
    always_comb begin
        pkt_service   = service;
        pkt_sender    = sender;
        pkt_receiver  = receiver;
        pkt_timestamp = timestamp;
        pkt_max       = (gap > max_gap) ? gap : max_gap;
        case (state)
            IDLE: begin
                pkt_service   = data_i[23:16];
                pkt_sender    = 16'd0;
                pkt_receiver  = 16'd0;
                pkt_timestamp = 32'd0;
                pkt_max       = 32'd0;
            end
            EDGE: begin
                pkt_sender   = data_i[31:16];
                pkt_receiver = data_i[15:0];
            end
            TIMESTAMP: pkt_timestamp = data_i;
            default: ;
        endcase
    end

    assign eligible     = !DELIVERY_ONLY || (service == MESSAGE_DELIVERY);
    assign pkt_eligible = !DELIVERY_ONLY || (pkt_service == MESSAGE_DELIVERY);
    assign rpt_fire     = xfer && eop_i && pkt_eligible && (pkt_max >= THRESHOLD);
    assign rpt_load     = rpt_fire && (!rpt_valid_o || rpt_ready_i);

    assign alarm_o = eligible && (state != IDLE) && (gap >= THRESHOLD);

    // Next state: advance only on a transfer, eop always returns to IDLE.
    always_comb begin
        state_nxt = state;
        if (xfer) begin
            if (eop_i) begin
                state_nxt = IDLE;
            end else begin
                case (state)
                    IDLE:      state_nxt = SRCPE;
                    SRCPE:     state_nxt = (service == MESSAGE_DELIVERY) ? EDGE : PAYLOAD;
                    EDGE:      state_nxt = TIMESTAMP;
                    TIMESTAMP: state_nxt = PAYLOAD;
                    default:   state_nxt = PAYLOAD;
                endcase
            end
        end
    end

    // FSM state and per-packet header registers, updated on every transfer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            service   <= 8'd0;
            sender    <= 16'd0;
            receiver  <= 16'd0;
            timestamp <= 32'd0;
            max_gap   <= 32'd0;
        end else begin
            state <= state_nxt;
            if (xfer) begin
                service   <= pkt_service;
                sender    <= pkt_sender;
                receiver  <= pkt_receiver;
                timestamp <= pkt_timestamp;
                max_gap   <= pkt_max;
            end
        end
    end

    // Saturating stall-gap counter, frozen outside packets.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gap <= 32'd0;
        end else if (xfer) begin
            gap <= 32'd0;
        end else if ((state != IDLE) && (gap != 32'hFFFF_FFFF)) begin
            gap <= gap + 32'd1;
        end
    end

    // One-entry report slot; a report arriving while the slot is held is dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rpt_valid_o     <= 1'b0;
            rpt_sender_o    <= 16'd0;
            rpt_receiver_o  <= 16'd0;
            rpt_timestamp_o <= 32'd0;
            rpt_max_gap_o   <= 32'd0;
            rpt_dropped_o   <= 8'd0;
        end else begin
            if (rpt_load) begin
                rpt_valid_o     <= 1'b1;
                rpt_sender_o    <= pkt_sender;
                rpt_receiver_o  <= pkt_receiver;
                rpt_timestamp_o <= pkt_timestamp;
                rpt_max_gap_o   <= pkt_max;
            end else if (rpt_valid_o && rpt_ready_i) begin
                rpt_valid_o <= 1'b0;
            end
            if (rpt_fire && !rpt_load && (rpt_dropped_o != 8'hFF)) begin
                rpt_dropped_o <= rpt_dropped_o + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_link_hang_monitor.sv
// Directed bench for link_hang_monitor: a vector table on a low-threshold
// instance plus hand sequences on default-parameter instances.
module tb_link_hang_monitor;

    localparam logic [7:0] MD = 8'h03;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx = 1'b0, cr = 1'b0, eop = 1'b0, rdy = 1'b0;
    logic [31:0] data = 32'd0;

    // u1: defaults (64, delivery only); u2: threshold 2, all packets;
    // u3: threshold 64, all packets.
    logic        a1, v1, a2, v2, a3, v3;
    logic [15:0] s1, r1, s2, r2, s3, r3;
    logic [31:0] t1, g1, t2, g2, t3, g3;
    logic [7:0]  d1, d2, d3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    link_hang_monitor u1 (
        .clk_i(clk), .rst_ni(rst_n), .tx_i(tx), .cr_i(cr), .eop_i(eop), .data_i(data),
        .alarm_o(a1), .rpt_valid_o(v1), .rpt_ready_i(rdy), .rpt_sender_o(s1),
        .rpt_receiver_o(r1), .rpt_timestamp_o(t1), .rpt_max_gap_o(g1), .rpt_dropped_o(d1));

    link_hang_monitor #(.THRESHOLD(32'd2), .DELIVERY_ONLY(1'b0)) u2 (
        .clk_i(clk), .rst_ni(rst_n), .tx_i(tx), .cr_i(cr), .eop_i(eop), .data_i(data),
        .alarm_o(a2), .rpt_valid_o(v2), .rpt_ready_i(rdy), .rpt_sender_o(s2),
        .rpt_receiver_o(r2), .rpt_timestamp_o(t2), .rpt_max_gap_o(g2), .rpt_dropped_o(d2));

    link_hang_monitor #(.THRESHOLD(32'd64), .DELIVERY_ONLY(1'b0)) u3 (
        .clk_i(clk), .rst_ni(rst_n), .tx_i(tx), .cr_i(cr), .eop_i(eop), .data_i(data),
        .alarm_o(a3), .rpt_valid_o(v3), .rpt_ready_i(rdy), .rpt_sender_o(s3),
        .rpt_receiver_o(r3), .rpt_timestamp_o(t3), .rpt_max_gap_o(g3), .rpt_dropped_o(d3));

    typedef struct {
        logic        tx, cr, eop, rdy;
        logic [31:0] data;
        logic        alarm, valid;
        logic [15:0] sender, receiver;
        logic [31:0] ts, max_gap;
        logic [7:0]  dropped;
    } vec_t;

    vec_t vecs[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic t, input logic c, input logic e, input logic [31:0] d);
        tx = t; cr = c; eop = e; data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tx = 0; cr = 0; eop = 0; rdy = 0; data = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Full packet; delivery packets carry edge/timestamp flits. The stall sits
    // before the first payload flit. u1's alarm is checked around stall 64.
    task automatic send_pkt(input logic [7:0] svc, input logic [31:0] edge_f,
                            input logic [31:0] ts_f, input int stall,
                            input logic credit_stall, input logic rdy_eop);
        logic exp_al;
        exp_al = (svc == MD);
        cyc(1, 1, 0, {8'hA5, svc, 16'h0042});
        cyc(1, 1, 0, 32'h0000_0007);
        if (svc == MD) begin
            cyc(1, 1, 0, edge_f);
            cyc(1, 1, 0, ts_f);
        end
        for (int k = 1; k <= stall; k++) begin
            if (credit_stall) cyc(1, 0, 0, 32'hBAD0_0000);
            else              cyc(0, 1, 0, 32'hBAD0_0000);
            if (k == 63) chk("alarm_before_thr", a1, 0);
            if (k == 64) chk("alarm_at_thr", a1, exp_al);
        end
        cyc(1, 1, 0, 32'h1111_0001);
        if (stall >= 64) chk("alarm_after_resume", a1, 0);
        cyc(1, 1, 0, 32'h1111_0002);
        rdy = rdy_eop;
        cyc(1, 1, 1, 32'h1111_0003);
        rdy = 1'b0;
        tx = 0; cr = 0; eop = 0;
    endtask

    initial begin
        //            tx cr eop rdy data           al vl snd      rcv      ts            max    drp
        vecs[0]  = '{1, 1, 0, 0, 32'h0003_0000, 0, 0, 16'h0, 16'h0, 32'h0, 32'd0, 8'd0};
        vecs[1]  = '{0, 1, 0, 0, 32'h0,         0, 0, 16'h0, 16'h0, 32'h0, 32'd0, 8'd0};
        vecs[2]  = '{0, 1, 0, 0, 32'h0,         1, 0, 16'h0, 16'h0, 32'h0, 32'd0, 8'd0};
        vecs[3]  = '{1, 1, 0, 0, 32'h1234_5678, 0, 0, 16'h0, 16'h0, 32'h0, 32'd0, 8'd0};
        vecs[4]  = '{1, 1, 0, 0, 32'h0102_0304, 0, 0, 16'h0, 16'h0, 32'h0, 32'd0, 8'd0};
        vecs[5]  = '{1, 0, 0, 0, 32'hFFFF_FFFF, 0, 0, 16'h0, 16'h0, 32'h0, 32'd0, 8'd0};
        vecs[6]  = '{1, 1, 0, 0, 32'h0000_1000, 0, 0, 16'h0, 16'h0, 32'h0, 32'd0, 8'd0};
        vecs[7]  = '{1, 1, 1, 0, 32'h0000_DEAD, 0, 1, 16'h0102, 16'h0304, 32'h1000, 32'd2, 8'd0};
        vecs[8]  = '{0, 0, 0, 0, 32'h0,         0, 1, 16'h0102, 16'h0304, 32'h1000, 32'd2, 8'd0};
        vecs[9]  = '{1, 1, 1, 0, 32'h0005_0000, 0, 1, 16'h0102, 16'h0304, 32'h1000, 32'd2, 8'd0};
        vecs[10] = '{1, 1, 0, 1, 32'h0007_0000, 0, 0, 16'h0102, 16'h0304, 32'h1000, 32'd2, 8'd0};
        vecs[11] = '{0, 1, 0, 0, 32'h0,         0, 0, 16'h0102, 16'h0304, 32'h1000, 32'd2, 8'd0};
        vecs[12] = '{0, 1, 0, 0, 32'h0,         1, 0, 16'h0102, 16'h0304, 32'h1000, 32'd2, 8'd0};
        vecs[13] = '{0, 0, 0, 0, 32'h0,         1, 0, 16'h0102, 16'h0304, 32'h1000, 32'd2, 8'd0};
        vecs[14] = '{1, 1, 1, 0, 32'hCAFE_0000, 0, 1, 16'h0, 16'h0, 32'h0, 32'd3, 8'd0};
        vecs[15] = '{1, 1, 1, 0, 32'h0003_0000, 0, 1, 16'h0, 16'h0, 32'h0, 32'd3, 8'd0};
        vecs[16] = '{1, 1, 0, 0, 32'h0003_0000, 0, 1, 16'h0, 16'h0, 32'h0, 32'd3, 8'd0};
        vecs[17] = '{0, 0, 0, 0, 32'h0,         0, 1, 16'h0, 16'h0, 32'h0, 32'd3, 8'd0};
        vecs[18] = '{0, 0, 0, 0, 32'h0,         1, 1, 16'h0, 16'h0, 32'h0, 32'd3, 8'd0};
        vecs[19] = '{1, 1, 1, 0, 32'h0,         0, 1, 16'h0, 16'h0, 32'h0, 32'd3, 8'd1};
        vecs[20] = '{1, 1, 0, 0, 32'h0003_0000, 0, 1, 16'h0, 16'h0, 32'h0, 32'd3, 8'd1};
        vecs[21] = '{0, 1, 0, 0, 32'h0,         0, 1, 16'h0, 16'h0, 32'h0, 32'd3, 8'd1};
        vecs[22] = '{0, 1, 0, 0, 32'h0,         1, 1, 16'h0, 16'h0, 32'h0, 32'd3, 8'd1};
        vecs[23] = '{1, 1, 1, 1, 32'h0,         0, 1, 16'h0, 16'h0, 32'h0, 32'd2, 8'd1};

        // Reset state, checked while reset is still asserted.
        #2;
        chk("rst_alarm", a1, 0);
        chk("rst_valid", v1, 0);
        chk("rst_dropped", d1, 0);
        chk("rst_max_gap", g1, 0);
        do_reset();

        // Vector table on u2 (threshold 2, all packets eligible).
        for (int i = 0; i < 24; i++) begin
            rdy = vecs[i].rdy;
            cyc(vecs[i].tx, vecs[i].cr, vecs[i].eop, vecs[i].data);
            chk($sformatf("v%0d_alarm", i), a2, vecs[i].alarm);
            chk($sformatf("v%0d_valid", i), v2, vecs[i].valid);
            chk($sformatf("v%0d_sender", i), s2, vecs[i].sender);
            chk($sformatf("v%0d_receiver", i), r2, vecs[i].receiver);
            chk($sformatf("v%0d_ts", i), t2, vecs[i].ts);
            chk($sformatf("v%0d_max_gap", i), g2, vecs[i].max_gap);
            chk($sformatf("v%0d_dropped", i), d2, vecs[i].dropped);
        end
        rdy = 0;

        // Unstalled delivery packet: no alarm, no report.
        do_reset();
        send_pkt(MD, 32'h0102_0304, 32'h0000_1000, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("clean_valid", v1, 0);
        chk("clean_alarm", a1, 0);

        // 100-cycle tx stall after the timestamp flit.
        do_reset();
        send_pkt(MD, 32'h0102_0304, 32'h0000_1000, 100, 0, 0);
        chk("hung_valid", v1, 1);
        chk("hung_sender", s1, 16'h0102);
        chk("hung_receiver", r1, 16'h0304);
        chk("hung_ts", t1, 32'h1000);
        chk("hung_max_gap", g1, 32'd100);
        rdy = 1;
        cyc(0, 0, 0, 0);
        rdy = 0;
        chk("hung_consumed", v1, 0);

        // Non-delivery hung packet: ignored by u1, reported by u3.
        do_reset();
        send_pkt(8'h09, 32'h0, 32'h0, 100, 0, 0);
        chk("nd_valid_u1", v1, 0);
        chk("nd_valid_u3", v3, 1);
        chk("nd_sender_u3", s3, 0);
        chk("nd_receiver_u3", r3, 0);
        chk("nd_ts_u3", t3, 0);
        chk("nd_max_gap_u3", g3, 32'd100);

        // Back-pressure: three hung packets with ready low, then a fourth
        // whose eop coincides with ready.
        do_reset();
        send_pkt(MD, 32'h1111_2222, 32'h0000_0A01, 70, 0, 0);
        send_pkt(MD, 32'h3333_4444, 32'h0000_0A02, 70, 0, 0);
        send_pkt(MD, 32'h5555_6666, 32'h0000_0A03, 70, 0, 0);
        chk("bp_valid", v1, 1);
        chk("bp_sender_held", s1, 16'h1111);
        chk("bp_ts_held", t1, 32'h0A01);
        chk("bp_dropped", d1, 8'd2);
        send_pkt(MD, 32'h7777_8888, 32'h0000_0A04, 70, 0, 1);
        chk("bp4_valid", v1, 1);
        chk("bp4_sender", s1, 16'h7777);
        chk("bp4_ts", t1, 32'h0A04);
        chk("bp4_dropped", d1, 8'd2);

        // Credit stall with tx held high, then a header-only packet, then
        // a packet that must parse from its header.
        do_reset();
        send_pkt(MD, 32'h0A0B_0C0D, 32'h0000_3000, 70, 1, 0);
        chk("cr_max_gap", g1, 32'd70);
        chk("cr_sender", s1, 16'h0A0B);
        rdy = 1;
        cyc(1, 1, 1, {8'h00, MD, 16'h0000});
        rdy = 0;
        chk("hdr_only_no_report", v1, 0);
        send_pkt(MD, 32'h0E0F_1011, 32'h0000_4000, 70, 0, 0);
        chk("after_hdr_sender", s1, 16'h0E0F);
        chk("after_hdr_receiver", r1, 16'h1011);
        chk("after_hdr_ts", t1, 32'h4000);

        // Reset during an alarm with a report pending.
        cyc(1, 1, 0, {8'h00, MD, 16'h0000});
        cyc(1, 1, 0, 32'h7);
        cyc(1, 1, 0, 32'h2222_3333);
        cyc(1, 1, 0, 32'h5000);
        for (int k = 0; k < 70; k++) cyc(0, 1, 0, 0);
        chk("pre_rst_alarm", a1, 1);
        rst_n = 0;
        #1;
        chk("mid_rst_alarm", a1, 0);
        chk("mid_rst_valid", v1, 0);
        chk("mid_rst_sender", s1, 0);
        chk("mid_rst_max_gap", g1, 0);
        chk("mid_rst_dropped", d1, 0);
        @(posedge clk); #1;
        rst_n = 1;
        send_pkt(MD, 32'h0C0D_0E0F, 32'h0000_2000, 70, 0, 0);
        chk("post_rst_valid", v1, 1);
        chk("post_rst_sender", s1, 16'h0C0D);
        chk("post_rst_receiver", r1, 16'h0E0F);
        chk("post_rst_ts", t1, 32'h2000);
        chk("post_rst_max_gap", g1, 32'd70);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
